// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin arbiter.
// Imported by rr_pick, rr_arbiter_if and rr_arbiter.
package arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  // Index width for n items. Clamped to at least 1 bit so a 1-entry range still has a port.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 64;
  localparam int IDX_W_DEF    = idx_w(N_REQ_DEF);
  localparam int CNT_W_DEF    = idx_w(MAX_HOLD_DEF);

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters, the shared resource and rr_arbiter.
// wdog_err exists only when ARB_WDOG_EN is defined.
interface rr_arbiter_if #(
  parameter int N_REQ = 4
) ();
  import arb_pkg::*;

  localparam int ID_W = idx_w(N_REQ);

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
`ifdef ARB_WDOG_EN
  logic             wdog_err;

  modport master (output req, done, input gnt, gnt_id, gnt_valid, wdog_err);
  modport slave  (input req, done, output gnt, gnt_id, gnt_valid, wdog_err);
`else
  modport master (output req, done, input gnt, gnt_id, gnt_valid);
  modport slave  (input req, done, output gnt, gnt_id, gnt_valid);
`endif

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority pick: first set req bit searching last+1, last+2, ... modulo N_REQ.
// Double-width masked priority encoder; purely combinational.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  pick,
  output logic             any
);

  logic [N_REQ-1:0]   mask;
  logic [2*N_REQ-1:0] dbl;

  // Lower copy keeps only bits above last; the upper copy supplies the wrapped-around tail.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (ID_W'(i) > last);
    end
    dbl  = {req, req & mask};
    pick = '0;
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (dbl[i]) pick = ID_W'(i % N_REQ);
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one registered one-hot grant, held until done, one bubble between grants.
// Optional hold watchdog enabled by defining ARB_WDOG_EN (adds wdog_err).
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arbiter_if.slave bus
);

  localparam int              ID_W     = idx_w(N_REQ);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_arbiter: N_REQ must be 2..16 and MAX_HOLD at least 1");
  end

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]  pick;
  logic             any;

`ifdef ARB_WDOG_EN
  localparam int              CNT_W     = idx_w(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             wdog_err_q, wdog_err_d;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (bus.req),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
`ifdef ARB_WDOG_EN
    hold_d      = hold_q;
    wdog_err_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d     = BUSY;
          last_d      = pick;
          gnt_d       = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          gnt_id_d    = pick;
          gnt_valid_d = 1'b1;
`ifdef ARB_WDOG_EN
          hold_d      = '0;
`endif
        end
      end
      BUSY: begin
        if (bus.done) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
`ifdef ARB_WDOG_EN
        // last_q is left on the offender so the next search starts just past it.
        end else if (hold_q == HOLD_LAST) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          wdog_err_d  = 1'b1;
        end else begin
          hold_d      = hold_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= LAST_RST;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
`ifdef ARB_WDOG_EN
      hold_q      <= '0;
      wdog_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
`ifdef ARB_WDOG_EN
      hold_q      <= hold_d;
      wdog_err_q  <= wdog_err_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
`ifdef ARB_WDOG_EN
  assign bus.wdog_err  = wdog_err_q;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed-vector bench for rr_arbiter (N_REQ=4, MAX_HOLD=8); watchdog scenario runs when ARB_WDOG_EN is defined.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_rr_arbiter;
  import arb_pkg::*;

  localparam int N_REQ    = 4;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rr_arbiter_if #(.N_REQ(N_REQ)) arb_if ();

  rr_arbiter #(.N_REQ(N_REQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_grant();
    arb_if.done = 1'b1;
    step();
    arb_if.done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b1;
    arb_if.req  = '0;
    arb_if.done = 1'b0;
    #2 rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({arb_if.gnt, arb_if.gnt_id, arb_if.gnt_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b id=%0d valid=%b want all zero", arb_if.gnt, arb_if.gnt_id, arb_if.gnt_valid);
    end
`ifdef ARB_WDOG_EN
    checks++;
    if (arb_if.wdog_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_wdog wdog_err=%b want 0", arb_if.wdog_err);
    end
`endif
    rst_n = 1'b1;
    step();
    release_grant();
    step();
    checks++;
    if ({arb_if.gnt, arb_if.gnt_valid} !== 5'b0) begin
      errors++;
      $display("FAIL idle_done_ignored gnt=%b valid=%b want 0000/0", arb_if.gnt, arb_if.gnt_valid);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_gnt;
    arb_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << order[k];
      step();
      checks++;
      if ({arb_if.gnt, arb_if.gnt_id, arb_if.gnt_valid} !== {exp_gnt, 2'(order[k]), 1'b1}) begin
        errors++;
        $display("FAIL rr_grant%0d gnt=%b id=%0d valid=%b want %b id %0d", k, arb_if.gnt, arb_if.gnt_id, arb_if.gnt_valid, exp_gnt, order[k]);
      end
      for (int c = 0; c < 2; c++) begin
        step();
        checks++;
        if (arb_if.gnt !== exp_gnt) begin
          errors++;
          $display("FAIL rr_hold%0d gnt=%b want %b", k, arb_if.gnt, exp_gnt);
        end
      end
      if (k == 4) arb_if.req = '0;
      release_grant();
      checks++;
      if ({arb_if.gnt, arb_if.gnt_valid} !== 5'b0) begin
        errors++;
        $display("FAIL rr_bubble%0d gnt=%b valid=%b want 0000/0", k, arb_if.gnt, arb_if.gnt_valid);
      end
    end
  endtask

  task automatic test_single_request();
    arb_if.req = 4'b0100;
    step();
    checks++;
    if ({arb_if.gnt, arb_if.gnt_id, arb_if.gnt_valid} !== {4'b0100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL single_req gnt=%b id=%0d valid=%b want 0100 id 2", arb_if.gnt, arb_if.gnt_id, arb_if.gnt_valid);
    end
    arb_if.req = '0;
    release_grant();
  endtask

  task automatic test_owner_drop();
    arb_if.req = 4'b0010;
    step();
    checks++;
    if ({arb_if.gnt, arb_if.gnt_id} !== {4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL drop_grant gnt=%b id=%0d want 0010 id 1", arb_if.gnt, arb_if.gnt_id);
    end
    for (int c = 2; c <= 5; c++) begin
      step();
      if (c == 2) arb_if.req = 4'b1101;
      checks++;
      if ({arb_if.gnt, arb_if.gnt_valid} !== {4'b0010, 1'b1}) begin
        errors++;
        $display("FAIL drop_hold_c%0d gnt=%b valid=%b want 0010/1", c, arb_if.gnt, arb_if.gnt_valid);
      end
    end
    release_grant();
    checks++;
    if (arb_if.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL drop_release gnt=%b want 0000", arb_if.gnt);
    end
    step();
    checks++;
    if ({arb_if.gnt, arb_if.gnt_id} !== {4'b0100, 2'd2}) begin
      errors++;
      $display("FAIL drop_next gnt=%b id=%0d want 0100 id 2", arb_if.gnt, arb_if.gnt_id);
    end
    arb_if.req = '0;
    release_grant();
  endtask

  task automatic test_wrap();
    arb_if.req = 4'b1000;
    step();
    checks++;
    if (arb_if.gnt_id !== 2'd3) begin
      errors++;
      $display("FAIL wrap_setup id=%0d want 3", arb_if.gnt_id);
    end
    arb_if.req = 4'b1001;
    release_grant();
    step();
    checks++;
    if ({arb_if.gnt, arb_if.gnt_id} !== {4'b0001, 2'd0}) begin
      errors++;
      $display("FAIL wrap_first gnt=%b id=%0d want 0001 id 0", arb_if.gnt, arb_if.gnt_id);
    end
    release_grant();
    step();
    checks++;
    if ({arb_if.gnt, arb_if.gnt_id} !== {4'b1000, 2'd3}) begin
      errors++;
      $display("FAIL wrap_second gnt=%b id=%0d want 1000 id 3", arb_if.gnt, arb_if.gnt_id);
    end
    arb_if.req = '0;
    release_grant();
  endtask

  task automatic test_reset_busy();
    arb_if.req = 4'b0010;
    step();
    checks++;
    if (arb_if.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rstbusy_grant gnt=%b want 0010", arb_if.gnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({arb_if.gnt, arb_if.gnt_valid} !== 5'b0) begin
      errors++;
      $display("FAIL rstbusy_async gnt=%b valid=%b want 0000/0", arb_if.gnt, arb_if.gnt_valid);
    end
    step();
    step();
    rst_n      = 1'b1;
    arb_if.req = 4'b1111;
    step();
    checks++;
    if ({arb_if.gnt, arb_if.gnt_id} !== {4'b0001, 2'd0}) begin
      errors++;
      $display("FAIL rstbusy_after gnt=%b id=%0d want 0001 id 0", arb_if.gnt, arb_if.gnt_id);
    end
    arb_if.req = '0;
    release_grant();
  endtask

`ifdef ARB_WDOG_EN
  task automatic test_watchdog();
    arb_if.req = 4'b0011;
    step();
    checks++;
    if ({arb_if.gnt, arb_if.gnt_id} !== {4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL wdog_grant gnt=%b id=%0d want 0010 id 1", arb_if.gnt, arb_if.gnt_id);
    end
    for (int c = 2; c <= MAX_HOLD; c++) begin
      step();
      checks++;
      if ({arb_if.gnt, arb_if.wdog_err} !== {4'b0010, 1'b0}) begin
        errors++;
        $display("FAIL wdog_hold_c%0d gnt=%b wdog_err=%b want 0010/0", c, arb_if.gnt, arb_if.wdog_err);
      end
    end
    step();
    checks++;
    if ({arb_if.gnt, arb_if.gnt_valid, arb_if.wdog_err} !== {4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wdog_fire gnt=%b valid=%b wdog_err=%b want 0000/0/1", arb_if.gnt, arb_if.gnt_valid, arb_if.wdog_err);
    end
    step();
    checks++;
    if ({arb_if.gnt, arb_if.gnt_id, arb_if.wdog_err} !== {4'b0001, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL wdog_next gnt=%b id=%0d wdog_err=%b want 0001 id 0, 0", arb_if.gnt, arb_if.gnt_id, arb_if.wdog_err);
    end
    for (int c = 2; c <= MAX_HOLD; c++) step();
    arb_if.req = '0;
    release_grant();
    checks++;
    if ({arb_if.gnt, arb_if.wdog_err} !== 5'b0) begin
      errors++;
      $display("FAIL wdog_done_wins gnt=%b wdog_err=%b want 0000/0", arb_if.gnt, arb_if.wdog_err);
    end
    step();
    checks++;
    if ({arb_if.gnt, arb_if.wdog_err} !== 5'b0) begin
      errors++;
      $display("FAIL wdog_quiet gnt=%b wdog_err=%b want 0000/0", arb_if.gnt, arb_if.wdog_err);
    end
  endtask
`else
  task automatic test_hold_forever();
    arb_if.req = 4'b0100;
    step();
    checks++;
    if (arb_if.gnt_id !== 2'd2) begin
      errors++;
      $display("FAIL hold_grant id=%0d want 2", arb_if.gnt_id);
    end
    for (int c = 0; c < 3 * MAX_HOLD; c++) step();
    checks++;
    if ({arb_if.gnt, arb_if.gnt_valid} !== {4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL hold_forever gnt=%b valid=%b want 0100/1", arb_if.gnt, arb_if.gnt_valid);
    end
    arb_if.req = '0;
    release_grant();
    checks++;
    if (arb_if.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL hold_release gnt=%b want 0000", arb_if.gnt);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL sim_timeout bench did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_request();
    test_owner_drop();
    test_wrap();
    test_reset_busy();
`ifdef ARB_WDOG_EN
    test_watchdog();
`else
    test_hold_forever();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
